// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory fetch block:
// default widths, the NOP filler word and the response-slot state encoding.
package instr_mem_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 4;
  localparam int          DEPTH_DEF    = 16;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int          CNT_W        = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage with synchronous, read-first access.
// The read register only loads on a read strobe so a stalled response holds.
module imem_array
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_ok,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: old word wins over a same-edge write, NOP for bad addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= NOP_WORD;
    end else if (rd_en) begin
      rd_data_r <= rd_ok ? mem_r[rd_addr] : NOP_WORD;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction fetch front end: single-slot valid/ready response register,
// out-of-range error flagging and a saturating completed-response counter.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic             accept_s;
  logic             consume_s;
  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             rsp_err_r;
  logic [CNT_W-1:0] fetch_cnt_r;

  assign rsp_valid = (state_r == ST_FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign consume_s = rsp_valid && rsp_ready;
  assign rd_ok_s   = ({1'b0, req_addr} < DEPTH_C);
  // Loads are dropped while reset is held and when they fall outside the array.
  assign wr_ok_s   = wr_en && rst_n && ({1'b0, wr_addr} < DEPTH_C);

  imem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_WORD)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok_s),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept_s),
    .rd_ok   (rd_ok_s),
    .rd_addr (req_addr),
    .rd_data (rsp_instr)
  );

  // Response slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response slot next-state: fill on accept, drain on consume without refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_nxt_s = ST_FULL;
        else          state_nxt_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (consume_s && !accept_s) state_nxt_s = ST_EMPTY;
        else                        state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Error flag travels with the fetched word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_r <= 1'b0;
    end else if (accept_s) begin
      rsp_err_r <= !rd_ok_s;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  // Completed-response counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r <= {CNT_W{1'b0}};
    end else if (consume_s && (fetch_cnt_r != {CNT_W{1'b1}})) begin
      fetch_cnt_r <= fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

  assign rsp_err   = rsp_err_r;
  assign fetch_cnt = fetch_cnt_r;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch (DEPTH=12) against a transaction-level
// model: a word array, one response slot and a saturating counter.
module tb_instr_mem_fetch;

  localparam int          DW  = 32;
  localparam int          AW  = 4;
  localparam int          DEP = 12;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_instr;
  logic          rsp_err;
  logic [15:0]   fetch_cnt;

  logic [31:0] mem_m [16];
  bit          exp_valid;
  logic [31:0] exp_instr;
  bit          exp_err;
  logic [15:0] exp_cnt;
  int          errors;
  int          checks;

  instr_mem_fetch #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEP),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .fetch_cnt (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Entered 1 time unit after a rising edge; checks outputs, advances the model, clocks once.
  task automatic step(input bit chk);
    bit acc;
    bit con;
    #1;
    if (chk) begin
      checks++;
      if (rsp_valid !== exp_valid) begin
        errors++; $display("FAIL step_rsp_valid: got %b expected %b", rsp_valid, exp_valid);
      end
      checks++;
      if (req_ready !== (!exp_valid || rsp_ready)) begin
        errors++; $display("FAIL step_req_ready: got %b expected %b", req_ready, (!exp_valid || rsp_ready));
      end
      checks++;
      if (fetch_cnt !== exp_cnt) begin
        errors++; $display("FAIL step_fetch_cnt: got %h expected %h", fetch_cnt, exp_cnt);
      end
      if (exp_valid) begin
        checks++;
        if (rsp_instr !== exp_instr) begin
          errors++; $display("FAIL step_rsp_instr: got %h expected %h", rsp_instr, exp_instr);
        end
        checks++;
        if (rsp_err !== exp_err) begin
          errors++; $display("FAIL step_rsp_err: got %b expected %b", rsp_err, exp_err);
        end
      end
    end
    con = exp_valid && rsp_ready;
    acc = req_valid && (!exp_valid || rsp_ready);
    if (con && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (acc) begin
      exp_valid = 1'b1;
      if (int'(req_addr) < DEP) begin
        exp_instr = mem_m[req_addr];
        exp_err   = 1'b0;
      end else begin
        exp_instr = NOP;
        exp_err   = 1'b1;
      end
    end else if (con) begin
      exp_valid = 1'b0;
    end
    if (wr_en && int'(wr_addr) < DEP) mem_m[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_instr !== NOP) begin errors++; $display("FAIL reset_rsp_instr: got %h expected %h", rsp_instr, NOP); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++;
    if (fetch_cnt !== 16'h0000) begin errors++; $display("FAIL reset_fetch_cnt: got %h expected 0000", fetch_cnt); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    exp_valid = 1'b0; exp_instr = NOP; exp_err = 1'b0; exp_cnt = 16'h0000;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_and_stream();
    logic [31:0] prog [8] = '{32'h8c0c0000, 32'h8c0d0001, 32'h8c0e0002, 32'h8c0f0003,
                              32'h01ad4820, 32'h01cf5020, 32'h01494022, 32'hac080004};
    for (int i = 0; i < DEP; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = (i < 8) ? prog[i] : $urandom;
      step(1);
    end
    wr_en = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = AW'(i);
      step(1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== prog[i] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL stream_word%0d: got v=%b %h e=%b expected v=1 %h e=0", i, rsp_valid, rsp_instr, rsp_err, prog[i]);
      end
    end
    req_valid = 1'b0;
    step(1);
    checks++;
    if (fetch_cnt !== 16'd8) begin errors++; $display("FAIL stream_fetch_cnt: got %0d expected 8", fetch_cnt); end
  endtask

  task automatic test_stall();
    logic [15:0] base;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd3;
    step(1);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8c0f0003 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b %h rdy=%b expected v=1 8c0f0003 rdy=0", i, rsp_valid, rsp_instr, req_ready);
      end
      step(1);
    end
    base = exp_cnt;
    rsp_ready = 1'b1;
    step(1);
    checks++;
    if (fetch_cnt !== base + 16'd1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got cnt=%h v=%b expected cnt=%h v=0", fetch_cnt, rsp_valid, base + 16'd1);
    end
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 4'd13;
    step(1);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h0000_0000 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL oor_fetch13: got v=%b %h e=%b expected v=1 00000000 e=1", rsp_valid, rsp_instr, rsp_err);
    end
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hcafe_f00d;
    step(1);
    wr_en = 1'b0; req_valid = 1'b1; req_addr = 4'd14;
    step(1);
    req_valid = 1'b0;
    checks++;
    if (rsp_instr !== 32'h0000_0000 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL oor_fetch14: got %h e=%b expected 00000000 e=1", rsp_instr, rsp_err);
    end
    step(1);
  endtask

  task automatic test_read_first();
    rsp_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hdeadbeef;
    req_valid = 1'b1; req_addr = 4'd5;
    step(1);
    wr_en = 1'b0;
    checks++;
    if (rsp_instr !== 32'h01cf5020) begin
      errors++; $display("FAIL read_first_old: got %h expected 01cf5020", rsp_instr);
    end
    step(1);
    req_valid = 1'b0;
    checks++;
    if (rsp_instr !== 32'hdeadbeef) begin
      errors++; $display("FAIL read_first_new: got %h expected deadbeef", rsp_instr);
    end
    step(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      step(1);
    end
    wr_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    step(1);
    step(1);
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 4'd2;
    step(1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || fetch_cnt !== 16'h0000 || rsp_instr !== NOP || rsp_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: got v=%b cnt=%h %h e=%b expected v=0 cnt=0000 %h e=0", rsp_valid, fetch_cnt, rsp_instr, rsp_err, NOP);
    end
    exp_valid = 1'b0; exp_instr = NOP; exp_err = 1'b0; exp_cnt = 16'h0000;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1);
    for (int i = 0; i < DEP; i++) begin
      req_valid = 1'b1; req_addr = AW'(i);
      step(1);
    end
    req_valid = 1'b0;
    step(1);
  endtask

  task automatic test_saturate();
    rsp_ready = 1'b1; req_valid = 1'b1; wr_en = 1'b0;
    req_addr = AW'($urandom_range(0, DEP - 1));
    while (exp_cnt < 16'hFFFE) step(0);
    #1;
    checks++;
    if (fetch_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preset: got %h expected fffe", fetch_cnt); end
    step(1);
    step(1);
    step(1);
    checks++;
    if (fetch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", fetch_cnt); end
    req_valid = 1'b0;
    step(1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_and_stream();
    test_stall();
    test_out_of_range();
    test_read_first();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
